// File: rtl/pipeline_delay_line.sv
// pipeline_delay_line
// Stallable delay line with a runtime-selectable tap (1..DEPTH stages).
// Each stage carries {valid, data}. The output tap is chosen by delay_q.
// The output is masked until the line has advanced delay_q times since the
// last clear (reset, flush or delay reload), so stale words never leak out.
module pipeline_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 32,
    parameter int DW    = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             delay_load,
    input  logic [DW-1:0]    delay,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             primed,
    output logic [DW-1:0]    fill_count
);

    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    // Stage k lives at index k, so the tap index equals the delay in stages.
    logic [DEPTH:1]            stage_vld;
    logic [DEPTH:1][WIDTH-1:0] stage_dat;
    logic [DW-1:0]             delay_q;
    logic [DW-1:0]             delay_clamped;
    logic                      sel_vld;
    logic [WIDTH-1:0]          sel_dat;

    // Clamp the requested delay into the legal range 1..DEPTH.
    always_comb begin
        delay_clamped = delay;
        if (delay == '0)
            delay_clamped = DW'(1);
        else if (delay > DEPTH_W)
            delay_clamped = DEPTH_W;
    end

    // Shift register: clear on reset/flush, shift one stage per enabled edge.
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            stage_vld <= '0;
            stage_dat <= '0;
        end else if (enable) begin
            stage_vld <= {stage_vld[DEPTH-1:1], in_valid};
            stage_dat <= {stage_dat[DEPTH-1:1], in};
        end
    end

    // Programmed delay: survives flush, returns to DEPTH on reset.
    always_ff @(posedge clock) begin
        if (!reset)
            delay_q <= DEPTH_W;
        else if (!flush && delay_load)
            delay_q <= delay_clamped;
    end

    // Advances since last clear; a reload restarts the count (counting this
    // edge if it also shifts). Saturates at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset || flush)
            fill_count <= '0;
        else if (delay_load)
            fill_count <= enable ? DW'(1) : '0;
        else if (enable && fill_count != DEPTH_W)
            fill_count <= fill_count + 1'b1;
    end

    // Output tap select; delay_q is always 1..DEPTH after reset.
    always_comb begin
        sel_vld = 1'b0;
        sel_dat = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (delay_q == DW'(k)) begin
                sel_vld = stage_vld[k];
                sel_dat = stage_dat[k];
            end
        end
    end

    assign primed    = (fill_count >= delay_q);
    assign out_valid = primed & sel_vld;
    assign out       = out_valid ? sel_dat : '0;

endmodule

// File: tb/tb_pipeline_delay_line.sv
// Directed bench for pipeline_delay_line (WIDTH=8, DEPTH=32, DW=6).
// A vector table covers bubbles, stall and in-place reload; hand-written
// sequences cover latency, clamping, flush, reset and reset-over-flush.
module tb_pipeline_delay_line;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       flush;
    logic       delay_load;
    logic [5:0] delay;
    logic       in_valid;
    logic [7:0] in;
    logic       out_valid;
    logic [7:0] out;
    logic       primed;
    logic [5:0] fill_count;

    int tests = 0;
    int fails = 0;

    pipeline_delay_line #(.WIDTH(8), .DEPTH(32), .DW(6)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .flush      (flush),
        .delay_load (delay_load),
        .delay      (delay),
        .in_valid   (in_valid),
        .in         (in),
        .out_valid  (out_valid),
        .out        (out),
        .primed     (primed),
        .fill_count (fill_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en;
        logic       dl;
        logic [5:0] dly;
        logic       iv;
        logic [7:0] din;
        logic       e_ov;
        logic [7:0] e_out;
        logic       e_pr;
        logic [5:0] e_fc;
    } vec_t;

    vec_t tbl[15];

    // Drive one cycle of inputs, then settle just after the rising edge.
    task automatic cyc(input logic rst, input logic en, input logic fl,
                       input logic dl, input logic [5:0] dly,
                       input logic iv, input logic [7:0] din);
        reset = rst; enable = en; flush = fl; delay_load = dl;
        delay = dly; in_valid = iv; in = din;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string nm, input logic ev, input logic [7:0] eo,
                       input logic ep, input logic [5:0] ef);
        tests++;
        if (out_valid !== ev || out !== eo || primed !== ep || fill_count !== ef) begin
            fails++;
            $display("FAIL %s: got ov=%0b out=%02h primed=%0b fill=%0d, want ov=%0b out=%02h primed=%0b fill=%0d",
                     nm, out_valid, out, primed, fill_count, ev, eo, ep, ef);
        end
    endtask

    initial begin
        // Delay 3 with bubbles, a 3-cycle stall, then reload to delay 0 (-> 1).
        //           en  dl  dly  iv  din    ov  out    pr  fc
        tbl[0]  = '{1'b1,1'b1,6'd3,1'b1,8'h11, 1'b0,8'h00, 1'b0,6'd1};
        tbl[1]  = '{1'b1,1'b0,6'd0,1'b0,8'h22, 1'b0,8'h00, 1'b0,6'd2};
        tbl[2]  = '{1'b1,1'b0,6'd0,1'b1,8'h33, 1'b1,8'h11, 1'b1,6'd3};
        tbl[3]  = '{1'b1,1'b0,6'd0,1'b0,8'h44, 1'b0,8'h00, 1'b1,6'd4};
        tbl[4]  = '{1'b1,1'b0,6'd0,1'b1,8'h55, 1'b1,8'h33, 1'b1,6'd5};
        tbl[5]  = '{1'b0,1'b0,6'd0,1'b1,8'h99, 1'b1,8'h33, 1'b1,6'd5};
        tbl[6]  = '{1'b0,1'b0,6'd0,1'b1,8'h99, 1'b1,8'h33, 1'b1,6'd5};
        tbl[7]  = '{1'b0,1'b0,6'd0,1'b1,8'h99, 1'b1,8'h33, 1'b1,6'd5};
        tbl[8]  = '{1'b1,1'b0,6'd0,1'b0,8'h66, 1'b0,8'h00, 1'b1,6'd6};
        tbl[9]  = '{1'b1,1'b0,6'd0,1'b1,8'h77, 1'b1,8'h55, 1'b1,6'd7};
        tbl[10] = '{1'b1,1'b0,6'd0,1'b1,8'h88, 1'b0,8'h00, 1'b1,6'd8};
        tbl[11] = '{1'b1,1'b0,6'd0,1'b1,8'h99, 1'b1,8'h77, 1'b1,6'd9};
        tbl[12] = '{1'b0,1'b1,6'd0,1'b1,8'hEE, 1'b0,8'h00, 1'b0,6'd0};
        tbl[13] = '{1'b1,1'b0,6'd0,1'b1,8'hAB, 1'b1,8'hAB, 1'b1,6'd1};
        tbl[14] = '{1'b1,1'b0,6'd0,1'b1,8'hCD, 1'b1,8'hCD, 1'b1,6'd2};

        // Reset state.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd5, 1'b1, 8'hFF);
        chk("reset_state", 1'b0, 8'h00, 1'b0, 6'd0);

        // Default delay 32: first word appears on the 32nd edge; fill saturates.
        for (int i = 1; i <= 40; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 8'(i));
            chk($sformatf("d32_stream_%0d", i), i >= 32, (i >= 32) ? 8'(i - 31) : 8'h00,
                i >= 32, (i >= 32) ? 6'd32 : 6'(i));
        end

        // Table-driven vectors.
        for (int v = 0; v < 15; v++) begin
            cyc(1'b1, tbl[v].en, 1'b0, tbl[v].dl, tbl[v].dly, tbl[v].iv, tbl[v].din);
            chk($sformatf("tbl_%0d", v), tbl[v].e_ov, tbl[v].e_out, tbl[v].e_pr, tbl[v].e_fc);
        end

        // Load delay 5 with enable; stale valid words must stay masked.
        for (int k = 1; k <= 16; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k == 1, 6'd5, 1'b1, 8'(8'hA0 + k - 1));
            chk($sformatf("d5_stream_%0d", k), k >= 5, (k >= 5) ? 8'(8'hA0 + k - 5) : 8'h00,
                k >= 5, 6'(k));
        end

        // Load 40 clamps to 32.
        for (int k = 1; k <= 34; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k == 1, 6'd40, 1'b1, 8'(k));
            if (k >= 30)
                chk($sformatf("d40_clamp_%0d", k), k >= 32, (k >= 32) ? 8'(k - 31) : 8'h00,
                    k >= 32, (k >= 32) ? 6'd32 : 6'(k));
        end

        // Flush with delay 6: word on the flush edge is discarded, delay kept.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k == 1, 6'd6, 1'b1, 8'(8'hC0 + k));
            if (k >= 5)
                chk($sformatf("d6_pre_%0d", k), k >= 6, (k >= 6) ? 8'(8'hC0 + k - 5) : 8'h00,
                    k >= 6, 6'(k));
        end
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b1, 8'hEE);
        chk("flush_clear", 1'b0, 8'h00, 1'b0, 6'd0);
        for (int j = 1; j <= 7; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 8'(8'hD0 + j));
            chk($sformatf("d6_post_%0d", j), j >= 6, (j >= 6) ? 8'(8'hD0 + j - 5) : 8'h00,
                j >= 6, 6'(j));
        end

        // Reset mid-stream with delay 7.
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k == 1, 6'd7, 1'b1, 8'(k));
            if (k >= 6)
                chk($sformatf("d7_pre_%0d", k), k >= 7, (k >= 7) ? 8'(k - 6) : 8'h00,
                    k >= 7, 6'(k));
        end
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 8'h77);
        chk("midstream_reset", 1'b0, 8'h00, 1'b0, 6'd0);
        for (int j = 1; j <= 33; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 8'(8'h50 + j));
            if (j == 7 || j >= 31)
                chk($sformatf("post_reset_%0d", j), j >= 32, (j >= 32) ? 8'(8'h50 + j - 31) : 8'h00,
                    j >= 32, (j >= 32) ? 6'd32 : 6'(j));
        end

        // Reset together with flush and delay_load: reset wins, delay_q = 32.
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 1'b1, 1'b0, k == 1, 6'd2, 1'b1, 8'(8'h60 + k));
        end
        chk("d2_before_rf", 1'b1, 8'h62, 1'b1, 6'd3);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 6'd3, 1'b1, 8'h6F);
        chk("reset_flush_clear", 1'b0, 8'h00, 1'b0, 6'd0);
        for (int j = 1; j <= 32; j++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 8'(8'h70 + j));
            if (j == 2 || j == 3 || j >= 31)
                chk($sformatf("after_rf_%0d", j), j >= 32, (j >= 32) ? 8'h71 : 8'h00,
                    j >= 32, 6'(j));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
